// File: rtl/adc_ram_half_averager.sv
// ---------------------------------------------------------------------------
// adc_ram_half_averager
// Consumer of the V/C ADC capture stage. It watches the ping-pong half flags
// of the shared V/C sample DPBRAM. When a half completes, the block reads
// every sample of that half through the second RAM port. It then produces
// one signed floor average for voltage and one for current.
//
// Optional build macro: ADC_AVG_MINMAX_EN adds per-block min/max outputs.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_ram_1_flag        capture writing lower half (falling edge = lower done)
//   i_ram_2_flag        capture writing upper half (falling edge = upper done)
//   o_ram_addr, o_ram_en  DPBRAM read port address / enable
//   i_v_ram_data, i_c_ram_data  read data, RAM_RD_LATENCY cycles after enable
//   o_v_avg, o_c_avg    signed block averages (hold until next result)
//   o_avg_valid         one-cycle pulse with new averages
//   o_avg_half          half that produced the current averages
//   i_overrun_clr       clears o_overrun
//   o_overrun           sticky: a half completed while a read was busy
//   o_v_min/max, o_c_min/max  (ADC_AVG_MINMAX_EN only) block extrema
//   o_debug_state       FSM state
// ---------------------------------------------------------------------------
module adc_ram_half_averager #(
  parameter int RAM_DEPTH      = 2048,
  parameter int RAM_RD_LATENCY = 1,
  parameter int DATA_WIDTH     = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ram_1_flag,
  input  logic                  i_ram_2_flag,
  output logic [14:0]           o_ram_addr,
  output logic                  o_ram_en,
  input  logic [DATA_WIDTH-1:0] i_v_ram_data,
  input  logic [DATA_WIDTH-1:0] i_c_ram_data,
  output logic [DATA_WIDTH-1:0] o_v_avg,
  output logic [DATA_WIDTH-1:0] o_c_avg,
  output logic                  o_avg_valid,
  output logic                  o_avg_half,
  input  logic                  i_overrun_clr,
  output logic                  o_overrun,
`ifdef ADC_AVG_MINMAX_EN
  output logic [DATA_WIDTH-1:0] o_v_min,
  output logic [DATA_WIDTH-1:0] o_v_max,
  output logic [DATA_WIDTH-1:0] o_c_min,
  output logic [DATA_WIDTH-1:0] o_c_max,
`endif
  output logic [2:0]            o_debug_state
);

  localparam int HALF  = RAM_DEPTH / 2;
  localparam int HW    = $clog2(HALF);
  localparam int ACC_W = DATA_WIDTH + HW;
  localparam int L     = RAM_RD_LATENCY;

  localparam logic [HW-1:0] K_LAST = HW'(HALF - 1);
  localparam logic [1:0]    D_LAST = 2'(L - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    flag1_q, flag2_q;
  logic [HW-1:0]           k_q, k_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic [14:0]             addr_q, addr_d;
  logic                    en_q, en_d;
  logic [L-1:0]            en_dly_q, en_dly_d;
  logic signed [ACC_W-1:0] v_acc_q, v_acc_d, c_acc_q, c_acc_d;
  logic                    half_q, half_d;
  logic [DATA_WIDTH-1:0]   v_avg_q, v_avg_d, c_avg_q, c_avg_d;
  logic                    avg_half_q, avg_half_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic                    fall1_s, fall2_s, req_s, ovr_set_s;
  logic signed [ACC_W-1:0] v_ext_s, c_ext_s, v_shr_s, c_shr_s;

`ifdef ADC_AVG_MINMAX_EN
  logic                         first_q, first_d;
  logic signed [DATA_WIDTH-1:0] v_min_t_q, v_min_t_d, v_max_t_q, v_max_t_d;
  logic signed [DATA_WIDTH-1:0] c_min_t_q, c_min_t_d, c_max_t_q, c_max_t_d;
  logic [DATA_WIDTH-1:0]        v_min_q, v_min_d, v_max_q, v_max_d;
  logic [DATA_WIDTH-1:0]        c_min_q, c_min_d, c_max_q, c_max_d;
  logic signed [DATA_WIDTH-1:0] v_smp_s, c_smp_s;

  assign v_smp_s = i_v_ram_data;
  assign c_smp_s = i_c_ram_data;
`endif

  // A falling flag means the capture stage has left that half, so it is full.
  assign fall1_s   = flag1_q & ~i_ram_1_flag;
  assign fall2_s   = flag2_q & ~i_ram_2_flag;
  assign req_s     = fall1_s | fall2_s;
  assign ovr_set_s = (req_s && (state_q != S_IDLE)) || (fall1_s && fall2_s);

  // Sign extension gives log2(N) guard bits, so N full-scale samples cannot overflow.
  assign v_ext_s = {{HW{i_v_ram_data[DATA_WIDTH-1]}}, i_v_ram_data};
  assign c_ext_s = {{HW{i_c_ram_data[DATA_WIDTH-1]}}, i_c_ram_data};
  assign v_shr_s = v_acc_q >>> HW;
  assign c_shr_s = c_acc_q >>> HW;

  // Next-state logic: FSM, read addressing, accumulation and result capture.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    dcnt_d     = dcnt_q;
    addr_d     = addr_q;
    en_d       = en_q;
    half_d     = half_q;
    v_avg_d    = v_avg_q;
    c_avg_d    = c_avg_q;
    avg_half_d = avg_half_q;
    valid_d    = 1'b0;
    // The enable shift register marks cycles where read data is valid.
    en_dly_d   = L'({en_dly_q, en_q});
    if (en_dly_q[L-1]) begin
      v_acc_d = v_acc_q + v_ext_s;
      c_acc_d = c_acc_q + c_ext_s;
    end else begin
      v_acc_d = v_acc_q;
      c_acc_d = c_acc_q;
    end
`ifdef ADC_AVG_MINMAX_EN
    first_d   = first_q;
    v_min_t_d = v_min_t_q;
    v_max_t_d = v_max_t_q;
    c_min_t_d = c_min_t_q;
    c_max_t_d = c_max_t_q;
    v_min_d   = v_min_q;
    v_max_d   = v_max_q;
    c_min_d   = c_min_q;
    c_max_d   = c_max_q;
    if (en_dly_q[L-1]) begin
      first_d   = 1'b0;
      v_min_t_d = (first_q || (v_smp_s < v_min_t_q)) ? v_smp_s : v_min_t_q;
      v_max_t_d = (first_q || (v_smp_s > v_max_t_q)) ? v_smp_s : v_max_t_q;
      c_min_t_d = (first_q || (c_smp_s < c_min_t_q)) ? c_smp_s : c_min_t_q;
      c_max_t_d = (first_q || (c_smp_s > c_max_t_q)) ? c_smp_s : c_max_t_q;
    end else begin
      first_d = first_q;
    end
`endif

    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (req_s) begin
          // Lower half wins if both edges arrive together.
          half_d  = ~fall1_s;
          addr_d  = fall1_s ? 15'd0 : 15'(HALF);
          en_d    = 1'b1;
          k_d     = '0;
          v_acc_d = '0;
          c_acc_d = '0;
`ifdef ADC_AVG_MINMAX_EN
          first_d = 1'b1;
`endif
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          en_d    = 1'b0;
          dcnt_d  = 2'd0;
          state_d = S_DRAIN;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + 15'd1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = S_DIV;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      S_DIV: begin
        v_avg_d    = v_shr_s[DATA_WIDTH-1:0];
        c_avg_d    = c_shr_s[DATA_WIDTH-1:0];
        avg_half_d = half_q;
        valid_d    = 1'b1;
`ifdef ADC_AVG_MINMAX_EN
        v_min_d = v_min_t_q;
        v_max_d = v_max_t_q;
        c_min_d = c_min_t_q;
        c_max_d = c_max_t_q;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A set in the same cycle as a clear takes priority.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (i_overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers; the flag history resets to "lower half active".
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      flag1_q    <= 1'b1;
      flag2_q    <= 1'b0;
      k_q        <= '0;
      dcnt_q     <= 2'd0;
      addr_q     <= 15'd0;
      en_q       <= 1'b0;
      en_dly_q   <= '0;
      v_acc_q    <= '0;
      c_acc_q    <= '0;
      half_q     <= 1'b0;
      v_avg_q    <= '0;
      c_avg_q    <= '0;
      avg_half_q <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag1_q    <= i_ram_1_flag;
      flag2_q    <= i_ram_2_flag;
      k_q        <= k_d;
      dcnt_q     <= dcnt_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      en_dly_q   <= en_dly_d;
      v_acc_q    <= v_acc_d;
      c_acc_q    <= c_acc_d;
      half_q     <= half_d;
      v_avg_q    <= v_avg_d;
      c_avg_q    <= c_avg_d;
      avg_half_q <= avg_half_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  // Running extrema and their published copies.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      first_q   <= 1'b0;
      v_min_t_q <= '0;
      v_max_t_q <= '0;
      c_min_t_q <= '0;
      c_max_t_q <= '0;
      v_min_q   <= '0;
      v_max_q   <= '0;
      c_min_q   <= '0;
      c_max_q   <= '0;
    end else begin
      first_q   <= first_d;
      v_min_t_q <= v_min_t_d;
      v_max_t_q <= v_max_t_d;
      c_min_t_q <= c_min_t_d;
      c_max_t_q <= c_max_t_d;
      v_min_q   <= v_min_d;
      v_max_q   <= v_max_d;
      c_min_q   <= c_min_d;
      c_max_q   <= c_max_d;
    end
  end

  assign o_v_min = v_min_q;
  assign o_v_max = v_max_q;
  assign o_c_min = c_min_q;
  assign o_c_max = c_max_q;
`endif

  assign o_ram_addr    = addr_q;
  assign o_ram_en      = en_q;
  assign o_v_avg       = v_avg_q;
  assign o_c_avg       = c_avg_q;
  assign o_avg_valid   = valid_q;
  assign o_avg_half    = avg_half_q;
  assign o_overrun     = ovr_q;
  assign o_debug_state = state_q;

endmodule

// File: tb/tb_adc_ram_half_averager.sv
// Directed bench: two instances (read latency 1 and 2) with RAM_DEPTH=8 share
// all stimulus, and each instance has its own behavioural DPBRAM read port.
module tb_adc_ram_half_averager;

  logic        clk = 1'b0;
  logic        rst, f1, f2, clr;
  logic [14:0] addr1, addr2;
  logic        en1, en2;
  logic [23:0] rdv1, rdc1, rdv2, rdc2, rdv2a, rdc2a;
  logic [23:0] vavg1, cavg1, vavg2, cavg2;
  logic        valid1, valid2, half1, half2, ovr1, ovr2;
  logic [2:0]  st1, st2;
`ifdef ADC_AVG_MINMAX_EN
  logic [23:0] vmin1, vmax1, cmin1, cmax1, vmin2, vmax2, cmin2, cmax2;
`endif

  logic [23:0] mem_v [8];
  logic [23:0] mem_c [8];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adc_ram_half_averager #(.RAM_DEPTH(8), .RAM_RD_LATENCY(1), .DATA_WIDTH(24)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_ram_1_flag(f1), .i_ram_2_flag(f2),
    .o_ram_addr(addr1), .o_ram_en(en1), .i_v_ram_data(rdv1), .i_c_ram_data(rdc1),
    .o_v_avg(vavg1), .o_c_avg(cavg1), .o_avg_valid(valid1), .o_avg_half(half1),
    .i_overrun_clr(clr), .o_overrun(ovr1),
`ifdef ADC_AVG_MINMAX_EN
    .o_v_min(vmin1), .o_v_max(vmax1), .o_c_min(cmin1), .o_c_max(cmax1),
`endif
    .o_debug_state(st1));

  adc_ram_half_averager #(.RAM_DEPTH(8), .RAM_RD_LATENCY(2), .DATA_WIDTH(24)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_ram_1_flag(f1), .i_ram_2_flag(f2),
    .o_ram_addr(addr2), .o_ram_en(en2), .i_v_ram_data(rdv2), .i_c_ram_data(rdc2),
    .o_v_avg(vavg2), .o_c_avg(cavg2), .o_avg_valid(valid2), .o_avg_half(half2),
    .i_overrun_clr(clr), .o_overrun(ovr2),
`ifdef ADC_AVG_MINMAX_EN
    .o_v_min(vmin2), .o_v_max(vmax2), .o_c_min(cmin2), .o_c_max(cmax2),
`endif
    .o_debug_state(st2));

  // RAM read port, latency 1
  always @(posedge clk) begin
    if (en1) begin
      rdv1 <= mem_v[addr1[2:0]];
      rdc1 <= mem_c[addr1[2:0]];
    end
  end

  // RAM read port, latency 2
  always @(posedge clk) begin
    if (en2) begin
      rdv2a <= mem_v[addr2[2:0]];
      rdc2a <= mem_c[addr2[2:0]];
    end
    rdv2 <= rdv2a;
    rdc2 <= rdc2a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs 16 cycles after the flag edge (cycle 0), checks the read addresses and
  // counts valid pulses / enable cycles. It can optionally inject a second
  // half-complete edge or a reset at a given cycle.
  task automatic run_read(input logic [14:0] base, input int ovr_cyc, input int rst_cyc,
                          output int vc1, output int vc2, output int n1, output int n2,
                          output int e1, output int e2);
    vc1 = 0; vc2 = 0; n1 = 0; n2 = 0; e1 = 0; e2 = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == rst_cyc + 1) rst = 1'b1;
      if (valid1) begin n1++; if (vc1 == 0) vc1 = c; end
      if (valid2) begin n2++; if (vc2 == 0) vc2 = c; end
      if (en1) e1++;
      if (en2) e2++;
      if (c <= 4) begin
        check("addr_l1", 32'(addr1), 32'(base) + 32'(c - 1));
        check("addr_l2", 32'(addr2), 32'(base) + 32'(c - 1));
      end
      if (c == ovr_cyc) begin
        f2 = 1'b0;
        f1 = 1'b1;
      end
      if (c == rst_cyc) begin
        rst = 1'b0;
        f1  = 1'b1;
        f2  = 1'b0;
        #1;
        check("rst_state", 32'(st1), 32'd0);
        check("rst_vavg", 32'(vavg1), 32'd0);
        check("rst_cavg2", 32'(cavg2), 32'd0);
        check("rst_en", 32'(en1), 32'd0);
        check("rst_addr", 32'(addr2), 32'd0);
        check("rst_valid", 32'({valid1, valid2}), 32'd0);
      end
    end
  endtask

  task automatic check_run(input int vc1, input int vc2, input int n1, input int n2,
                           input int e1, input int e2, input int xv1, input int xv2, input int xn);
    check("valid_cyc_l1", 32'(vc1), 32'(xv1));
    check("valid_cyc_l2", 32'(vc2), 32'(xv2));
    check("valid_cnt_l1", 32'(n1), 32'(xn));
    check("valid_cnt_l2", 32'(n2), 32'(xn));
    check("en_cnt_l1", 32'(e1), 32'd4);
    check("en_cnt_l2", 32'(e2), 32'd4);
  endtask

  task automatic check_avg(input logic [23:0] xv, input logic [23:0] xc, input logic xh);
    check("v_avg_l1", 32'(vavg1), 32'(xv));
    check("c_avg_l1", 32'(cavg1), 32'(xc));
    check("v_avg_l2", 32'(vavg2), 32'(xv));
    check("c_avg_l2", 32'(cavg2), 32'(xc));
    check("half_l1", 32'(half1), 32'(xh));
    check("half_l2", 32'(half2), 32'(xh));
  endtask

  int vc1, vc2, n1, n2, e1, e2;

  initial begin
    rst = 1'b0; f1 = 1'b1; f2 = 1'b0; clr = 1'b0;
    mem_v[0] = 24'd10;  mem_c[0] = 24'hFFFFFF;
    mem_v[1] = 24'd20;  mem_c[1] = 24'hFFFFFE;
    mem_v[2] = 24'd30;  mem_c[2] = 24'hFFFFFD;
    mem_v[3] = 24'd40;  mem_c[3] = 24'hFFFFFC;
    for (int i = 4; i < 8; i++) begin
      mem_v[i] = 24'h7FFFFF;
      mem_c[i] = 24'h800000;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(st1), 32'd0);
    check("reset_outs", 32'({en1, valid1, half1, ovr1, en2, valid2, ovr2}), 32'd0);
    check("reset_avg", 32'(vavg1 | cavg1 | vavg2), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("no_edge_at_release", 32'(st1), 32'd0);

    // Lower half complete: V avg 25, C avg floor(-2.5) = -3
    f1 = 1'b0; f2 = 1'b1;
    run_read(15'd0, -1, -1, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 7, 8, 1);
    check_avg(24'd25, 24'hFFFFFD, 1'b0);
    check("ovr_clean", 32'({ovr1, ovr2}), 32'd0);

    // Upper half complete at full scale: no overflow
    @(negedge clk); f2 = 1'b0; f1 = 1'b1;
    run_read(15'd4, -1, -1, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 7, 8, 1);
    check_avg(24'h7FFFFF, 24'h800000, 1'b1);

    // Upper-half edge during READ of lower half: dropped, overrun set
    @(negedge clk); f1 = 1'b0; f2 = 1'b1;
    run_read(15'd0, 2, -1, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 7, 8, 1);
    check_avg(24'd25, 24'hFFFFFD, 1'b0);
    check("ovr_set", 32'({ovr1, ovr2}), 32'd3);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovr_clr", 32'({ovr1, ovr2}), 32'd0);

    // Reset in DRAIN: no result, outputs cleared
    @(negedge clk); f1 = 1'b0; f2 = 1'b1;
    run_read(15'd0, -1, 5, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 0, 0, 0);
    check_avg(24'd0, 24'd0, 1'b0);

    // Recovery read after reset
    @(negedge clk); f1 = 1'b0; f2 = 1'b1;
    run_read(15'd0, -1, -1, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 7, 8, 1);
    check_avg(24'd25, 24'hFFFFFD, 1'b0);

    // Mixed-sign data in upper half: V=5,-7,3,1 -> 0; C=-1..-4 -> -3
    mem_v[4] = 24'd5;  mem_v[5] = 24'hFFFFF9; mem_v[6] = 24'd3; mem_v[7] = 24'd1;
    mem_c[4] = 24'hFFFFFF; mem_c[5] = 24'hFFFFFE; mem_c[6] = 24'hFFFFFD; mem_c[7] = 24'hFFFFFC;
    @(negedge clk); f2 = 1'b0; f1 = 1'b1;
    run_read(15'd4, -1, -1, vc1, vc2, n1, n2, e1, e2);
    check_run(vc1, vc2, n1, n2, e1, e2, 7, 8, 1);
    check_avg(24'd0, 24'hFFFFFD, 1'b1);
    check("ovr_end", 32'({ovr1, ovr2}), 32'd0);
`ifdef ADC_AVG_MINMAX_EN
    check("v_min_l1", 32'(vmin1), 32'h00FFFFF9);
    check("v_max_l1", 32'(vmax1), 32'd5);
    check("c_min_l1", 32'(cmin1), 32'h00FFFFFC);
    check("c_max_l1", 32'(cmax1), 32'h00FFFFFF);
    check("v_min_l2", 32'(vmin2), 32'h00FFFFF9);
    check("v_max_l2", 32'(vmax2), 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
